// File: rtl/flag_branch_unit.sv
// Architectural NZVC flag register plus conditional-branch resolver for the 5-stage pipeline.
// A taken branch issues a one-cycle registered PC redirect and then holds flush for SQUASH_CYCLES cycles.
module flag_branch_unit #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_setflags,
  input  logic [3:0]       ex_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic             cbz_zero,
  input  logic [63:0]      br_pc,
  input  logic [63:0]      br_offset,
  output logic [3:0]       flags,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic             dbg_state
);

  // Handshake: br_valid and ex_valid are single-cycle qualifiers with no ready;
  // the unit accepts whatever is presented on an edge while in IDLE and
  // silently drops it while in SQUASH (that work is on the wrong path).

  localparam int SQ_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;

  localparam logic [1:0] BR_B   = 2'b00;
  localparam logic [1:0] BR_CBZ = 2'b01;
  localparam logic [1:0] BR_EQ  = 2'b10;
  localparam logic [1:0] BR_LT  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t          state;
  logic [SQ_W-1:0] sq_cnt;

  logic            fwd_sel;
  logic            eff_n;
  logic            eff_z;
  logic            eff_v;
  logic            taken;
  logic [63:0]     target;

  // The EX instruction is always older than the branch, so its flags win.
  assign fwd_sel = ex_valid & ex_setflags;
  assign eff_n   = fwd_sel ? ex_flags[3] : flags[3];
  assign eff_z   = fwd_sel ? ex_flags[2] : flags[2];
  assign eff_v   = fwd_sel ? ex_flags[1] : flags[1];

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_B:    taken = 1'b1;
      BR_CBZ:  taken = cbz_zero;
      BR_EQ:   taken = eff_z;
      BR_LT:   taken = eff_n ^ eff_v;
      default: taken = 1'b0;
    endcase
  end

  // Modular add: a target past the top of the address space wraps to low memory.
  assign target = br_pc + br_offset;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      sq_cnt         <= '0;
      flags          <= 4'b0000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 64'd0;
      flush          <= 1'b0;
      br_count       <= '0;
      taken_count    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fwd_sel) begin
            flags <= ex_flags;
          end
          if (br_valid) begin
            br_count <= sat_inc(br_count);
            if (taken) begin
              taken_count    <= sat_inc(taken_count);
              redirect_pc    <= target;
              redirect_valid <= 1'b1;
              flush          <= 1'b1;
              sq_cnt         <= SQ_W'(SQUASH_CYCLES - 1);
              state          <= SQUASH;
            end
          end
        end
        SQUASH: begin
          if (sq_cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            sq_cnt <= sq_cnt - SQ_W'(1);
          end
        end
        default: begin
          flush <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed branch scenarios with a redirect-target scoreboard.
// A second instance with 4-bit counters shares the stimulus to exercise counter saturation.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_setflags;
  logic [3:0]  ex_flags;
  logic        br_valid;
  logic [1:0]  br_type;
  logic        cbz_zero;
  logic [63:0] br_pc;
  logic [63:0] br_offset;

  logic [3:0]  flags;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic [15:0] br_count;
  logic [15:0] taken_count;
  logic        dbg_state;

  logic [3:0]  sat_flags;
  logic        sat_redirect_valid;
  logic [63:0] sat_redirect_pc;
  logic        sat_flush;
  logic [3:0]  sat_br_count;
  logic [3:0]  sat_taken_count;
  logic        sat_dbg_state;

  int checks = 0;
  int failures = 0;
  int redirects_seen = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  flag_branch_unit #(.SQUASH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_flags(ex_flags), .br_valid(br_valid), .br_type(br_type), .cbz_zero(cbz_zero),
    .br_pc(br_pc), .br_offset(br_offset), .flags(flags), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .br_count(br_count),
    .taken_count(taken_count), .dbg_state(dbg_state)
  );

  flag_branch_unit #(.SQUASH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_setflags(ex_setflags),
    .ex_flags(ex_flags), .br_valid(br_valid), .br_type(br_type), .cbz_zero(cbz_zero),
    .br_pc(br_pc), .br_offset(br_offset), .flags(sat_flags),
    .redirect_valid(sat_redirect_valid), .redirect_pc(sat_redirect_pc), .flush(sat_flush),
    .br_count(sat_br_count), .taken_count(sat_taken_count), .dbg_state(sat_dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every redirect pulse pops the target pushed when the branch was driven.
  always @(negedge clk) begin
    if (redirect_valid === 1'b1) begin
      redirects_seen++;
      if (exp_q.size() == 0) check("unexpected_redirect", redirect_pc, 64'hx);
      else check("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_setflags = 0; ex_flags = 4'b0000;
    br_valid = 0; br_type = 2'b00; cbz_zero = 0; br_pc = 64'd0; br_offset = 64'd0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    ex_valid = 1; ex_setflags = 1; ex_flags = f;
    step();
    ex_valid = 0; ex_setflags = 0;
  endtask

  // Drives one branch for one edge; a taken branch queues its target (computed here).
  task automatic issue_branch(input logic [1:0] t, input logic [63:0] pc, input logic [63:0] off,
                              input logic cz, input logic exp_taken);
    br_valid = 1; br_type = t; br_pc = pc; br_offset = off; cbz_zero = cz;
    if (exp_taken) exp_q.push_back(pc + off);
    step();
    br_valid = 0; cbz_zero = 0;
  endtask

  // ---------------- main sequence ----------------
  int seen_before;

  initial begin
    idle_inputs();
    reset = 0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ex_valid = 1'($urandom_range(0, 1)); ex_setflags = 1'($urandom_range(0, 1));
      ex_flags = 4'($urandom_range(0, 15)); br_valid = 1'($urandom_range(0, 1));
      br_type = 2'($urandom_range(0, 3)); cbz_zero = 1'($urandom_range(0, 1));
      br_pc = {$urandom, $urandom}; br_offset = {$urandom, $urandom};
    end
    step();
    check("rst_flags", 64'(flags), 64'h0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'h0);
    check("rst_redirect_pc", redirect_pc, 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_br_count", 64'(br_count), 64'h0);
    check("rst_taken_count", 64'(taken_count), 64'h0);
    idle_inputs();
    reset = 1;
    step();
    step();
    check("post_rst_flush", 64'(flush), 64'h0);
    check("post_rst_counts", {32'(br_count), 32'(taken_count)}, 64'h0);
    check("post_rst_redirect_pc", redirect_pc, 64'h0);

    // CBZ taken then not taken
    issue_branch(2'b01, 64'h100, 64'h40, 1'b1, 1'b1);
    check("cbz_redirect_valid", 64'(redirect_valid), 64'h1);
    check("cbz_flush_c1", 64'(flush), 64'h1);
    check("cbz_state", 64'(dbg_state), 64'h1);
    check("cbz_taken_count", 64'(taken_count), 64'd1);
    step();
    check("cbz_redirect_pulse_end", 64'(redirect_valid), 64'h0);
    check("cbz_flush_c2", 64'(flush), 64'h1);
    check("cbz_redirect_pc_hold", redirect_pc, 64'h140);
    step();
    check("cbz_flush_done", 64'(flush), 64'h0);
    issue_branch(2'b01, 64'h100, 64'h40, 1'b0, 1'b0);
    check("cbz_nt_redirect", 64'(redirect_valid), 64'h0);
    check("cbz_nt_br_count", 64'(br_count), 64'd2);
    check("cbz_nt_taken_count", 64'(taken_count), 64'd1);

    // Forwarding: flag-setting EX alongside B.EQ
    ex_valid = 1; ex_setflags = 1; ex_flags = 4'b0100;
    issue_branch(2'b10, 64'h200, 64'h8, 1'b0, 1'b1);
    ex_valid = 0; ex_setflags = 0;
    check("fwd_beq_taken", 64'(redirect_valid), 64'h1);
    check("fwd_flags_commit", 64'(flags), 64'h4);
    step(); step();
    set_flags(4'b1000);
    check("flags_n", 64'(flags), 64'h8);
    issue_branch(2'b11, 64'h300, 64'h10, 1'b0, 1'b1);
    check("blt_nv0_taken", 64'(redirect_valid), 64'h1);
    step(); step();
    set_flags(4'b1010);
    issue_branch(2'b11, 64'h300, 64'h10, 1'b0, 1'b0);
    check("blt_nv1_not_taken", 64'(redirect_valid), 64'h0);
    issue_branch(2'b10, 64'h340, 64'h10, 1'b0, 1'b0);
    check("beq_z0_not_taken", 64'(redirect_valid), 64'h0);
    check("fwd_br_count", 64'(br_count), 64'd6);
    check("fwd_taken_count", 64'(taken_count), 64'd3);

    // Squash window ignores branches and flag writes
    seen_before = redirects_seen;
    issue_branch(2'b00, 64'h400, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b1);
    br_valid = 1; br_type = 2'b00; br_pc = 64'h500; br_offset = 64'h4;
    ex_valid = 1; ex_setflags = 1; ex_flags = 4'b1111;
    step(); step();
    idle_inputs();
    check("sq_flags_held", 64'(flags), 64'hA);
    check("sq_br_count", 64'(br_count), 64'd7);
    check("sq_taken_count", 64'(taken_count), 64'd4);
    check("sq_flush_done", 64'(flush), 64'h0);
    step();
    check("sq_one_redirect", 64'(redirects_seen - seen_before), 64'd1);

    // Wrapping target, then reset during the second flush cycle
    issue_branch(2'b00, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 1'b1);
    step();
    check("wrap_flush_c2", 64'(flush), 64'h1);
    check("wrap_redirect_pc", redirect_pc, 64'h10);
    reset = 0;
    step();
    reset = 1;
    check("rst_mid_flush", 64'(flush), 64'h0);
    check("rst_mid_counts", {32'(br_count), 32'(taken_count)}, 64'h0);
    check("rst_mid_flags", 64'(flags), 64'h0);

    // Reset during the first flush cycle must cut the window short
    issue_branch(2'b00, 64'h600, 64'h20, 1'b0, 1'b1);
    reset = 0;
    step();
    reset = 1;
    check("rst_early_flush", 64'(flush), 64'h0);
    check("rst_early_state", 64'(dbg_state), 64'h0);
    check("rst_early_redirect_pc", redirect_pc, 64'h0);

    // Saturation: 20 taken branches spaced SQUASH_CYCLES+1 apart
    for (int i = 0; i < 20; i++) begin
      issue_branch(2'b00, 64'h1000 + 64'(i * 16), 64'h80, 1'b0, 1'b1);
      step(); step();
      if (i == 14) check("sat_at_15", 64'(sat_br_count), 64'hF);
      if (i == 15) check("sat_no_wrap_16", 64'(sat_taken_count), 64'hF);
    end
    check("sat_br_count", 64'(sat_br_count), 64'hF);
    check("sat_taken_count", 64'(sat_taken_count), 64'hF);
    check("wide_br_count", 64'(br_count), 64'd20);
    check("wide_taken_count", 64'(taken_count), 64'd20);

    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumes the ALU condition flags (N, Z, V, C) and the CBZ zero-detect result, holds the architectural flag register, and resolves conditional branches for the 5-stage pipeline. It sits between EX (the flag producer) and fetch/pipeline control (the redirect consumer). It issues a registered one-cycle PC redirect plus a multi-cycle flush window that squashes wrong-path work, and keeps saturating branch statistics.

## Interface
Parameters:
- SQUASH_CYCLES, 2, number of cycles `flush` stays high after a taken branch (legal range ≥1)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- ex_valid  input  1  EX-stage instruction is valid
- ex_setflags  input  1  EX instruction writes flags (ADDS/SUBS class)
- ex_flags  input  4  {N,Z,V,C} from the ALU this cycle
- br_valid  input  1  branch presented for resolution this cycle
- br_type  input  2  00 B (always), 01 CBZ, 10 B.EQ, 11 B.LT
- cbz_zero  input  1  1 when the CBZ source register is all-zero (from the 64-bit zero detector)
- br_pc  input  64  PC of the branch
- br_offset  input  64  byte offset, already sign-extended and shifted
- flags  output  4  architectural {N,Z,V,C}
- redirect_valid  output  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  output  64  branch target
- flush  output  1  squash younger pipeline stages
- br_count  output  CNT_W  branches resolved (not squashed)
- taken_count  output  CNT_W  branches taken

## Operation
- Flag register: on an edge with ex_valid & ex_setflags & state==IDLE, flags <= ex_flags; otherwise it holds.
- Effective flags for evaluation (combinational forwarding): ex_flags when ex_valid & ex_setflags, else flags register. The EX instruction is always older than the branch.
- Condition: B always taken; CBZ taken iff cbz_zero; B.EQ taken iff eff Z; B.LT taken iff eff N != eff V. C is stored but not used by any condition.
- Target = br_pc + br_offset, 64-bit modular (carry out discarded; wrap-around is legal).
- FSM states: IDLE, SQUASH.
  - IDLE: br_valid increments br_count. If the branch is taken, taken_count increments, redirect_pc <= target, and the FSM moves to SQUASH with squash counter = SQUASH_CYCLES-1. A not-taken branch stays in IDLE.
  - SQUASH: flush=1. br_valid and ex_setflags are ignored: no flag update, no count, no new redirect. The counter decrements each cycle. When it is 0 on an edge, the FSM returns to IDLE.
- Simultaneous flag-setting EX instruction and taken branch in IDLE: the flag update commits, and the branch evaluates using the forwarded ex_flags.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset (reset==0 at an edge) forces: state IDLE, flags=4'b0000, redirect_valid=0, redirect_pc=0, flush=0, br_count=0, taken_count=0. Reset overrides every other input.
- Reset in mid-SQUASH aborts the window. flush is 0 from the next cycle.
- A taken branch sampled at edge t gives redirect_valid=1 during cycle t+1 only.
- flush=1 during cycles t+1 … t+SQUASH_CYCLES, then 0.
- A branch at cycle t+SQUASH_CYCLES+1 is evaluated normally. Back-to-back taken branches are therefore spaced by at least SQUASH_CYCLES+1 cycles.
- redirect_pc holds its last value when redirect_valid=0.
- flags output reflects the register, not the forwarded value. An update is visible one cycle after the setting instruction.
- redirect_valid, redirect_pc and flush are registered, with no combinational path from inputs. Only the internal condition evaluation is combinational.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs. All outputs must be 0. Release reset; outputs stay 0 with br_valid=0.
- CBZ: br_pc=64'h100, br_offset=64'h40, cbz_zero=1, br_type=01. Require redirect_valid pulse at t+1 with redirect_pc=64'h140, flush high for exactly 2 cycles, taken_count=1. Repeat with cbz_zero=0: no redirect, br_count=2, taken_count=1.
- Forwarding: set ex_setflags=1 with ex_flags=4'b0100 (Z) and a B.EQ in the same cycle. The branch must be taken, and flags=4'b0100 on the next cycle. Then B.LT with flags N=1, V=0: taken. With N=1, V=1: not taken.
- Squash: hold a taken B at t, and during the flush cycles present br_valid B and ex_setflags with ex_flags=4'b1111. Require no second redirect, flags unchanged, and counters unchanged by those cycles.
- Wrap and reset mid-window: br_pc=64'hFFFF_FFFF_FFFF_FFF0, offset=64'h20 gives redirect_pc=64'h10. Assert reset during the second flush cycle: flush=0 the following cycle and counters=0.
- Saturation: with CNT_W=4, issue 20 taken branches spaced SQUASH_CYCLES+1 apart. Require br_count=taken_count=4'hF, with no wrap.
